wb_burst_ram: RTL and testbench

- Synthesizable Wishbone B3 slave memory.
- Sits directly downstream of the Wishbone master BFM and consumes its classic, constant-address and incrementing burst cycles.
- Serves as the default target in BFM-driven benches and as a small on-chip RAM in real designs.
- Classic cycles complete in 2 clocks; registered-feedback bursts sustain one beat per clock after a 1-cycle first-beat latency.

---
 rtl/wb_burst_ram_pkg.sv | 48 ++++
 rtl/wb_burst_ram_next_adr.sv | 35 +++
 rtl/wb_burst_ram.sv | 173 +++++++++++++++++
 tb/tb_wb_burst_ram.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_burst_ram_pkg.sv
// -----------------------------------------------------------------------------
// wb_burst_ram_pkg
// Shared Wishbone B3 constants for the burst RAM slave and its address
// sequencer: cycle type identifiers, burst type extensions, transfer
// direction encodings, slave FSM state codes and a byte-lane merge helper.
// No ports (package).
// -----------------------------------------------------------------------------
package wb_burst_ram_pkg;

  // Cycle type identifier (wb_cti_i)
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Burst type extension (wb_bte_i)
  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  // Transfer direction (wb_we_i)
  localparam logic WB_READ  = 1'b0;
  localparam logic WB_WRITE = 1'b1;

  // Slave FSM state codes
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CLASSIC = 2'd1;
  localparam logic [1:0] ST_BURST   = 2'd2;

  // Cycle types that keep the slave streaming beats back to back.
  function automatic logic is_burst(input logic [2:0] cti);
    return (cti == CTI_CONST) || (cti == CTI_INCR);
  endfunction

  // Replace the selected byte lanes of old_word with new_word.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_burst_ram_next_adr.sv
// -----------------------------------------------------------------------------
// wb_next_adr
// Combinational Wishbone burst address sequencer. Produces the byte address
// of the beat following i_adr for the given cycle type and burst extension.
// Also used by the master BFM model checker, so it carries no state.
//   i_adr  [aw-1:0]  current beat byte address
//   i_cti  [2:0]     cycle type identifier
//   i_bte  [1:0]     burst type extension
//   o_adr  [aw-1:0]  next beat byte address
// -----------------------------------------------------------------------------
module wb_next_adr
  import wb_burst_ram_pkg::*;
#(
  parameter int aw = 32
) (
  input  logic [aw-1:0] i_adr,
  input  logic [2:0]    i_cti,
  input  logic [1:0]    i_bte,
  output logic [aw-1:0] o_adr
);

  always_comb begin
    // NOTE: default assignment first so every path drives o_adr (no latch).
    o_adr = i_adr;
    if (i_cti != CTI_CONST) begin
      case (i_bte)
        BTE_LINEAR: o_adr = i_adr + aw'(4);          // wraps modulo 2^aw
        BTE_WRAP4:  o_adr[3:2] = i_adr[3:2] + 2'd1;  // upper bits held
        BTE_WRAP8:  o_adr[4:2] = i_adr[4:2] + 3'd1;
        default:    o_adr[5:2] = i_adr[5:2] + 4'd1;  // BTE_WRAP16
      endcase
    end
  end

endmodule

// File: rtl/wb_burst_ram.sv
// -----------------------------------------------------------------------------
// wb_burst_ram
// Wishbone B3 slave RAM (DEPTH x 32-bit words) supporting classic cycles
// (2 clocks each) and registered-feedback constant/incrementing bursts
// (one beat per clock after a 1-cycle first-beat latency). Accesses at or
// beyond DEPTH*4 bytes are answered with err and never written.
//   wb_clk_i   clock, rising edge
//   wb_rst_ni  asynchronous active-low reset
//   wb_adr_i   byte address          wb_dat_i  write data
//   wb_sel_i   byte-lane enables     wb_we_i   write enable
//   wb_cyc_i   cycle valid           wb_stb_i  strobe
//   wb_cti_i   cycle type            wb_bte_i  burst type extension
//   wb_dat_o   read data             wb_ack_o  beat acknowledge
//   wb_err_o   beat error            wb_rty_o  retry (always 0)
// -----------------------------------------------------------------------------
module wb_burst_ram
  import wb_burst_ram_pkg::*;
#(
  parameter int aw    = 32,
  parameter int dw    = 32,
  parameter int DEPTH = 256
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic [aw-1:0] wb_adr_i,
  input  logic [dw-1:0] wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic [2:0]    wb_cti_i,
  input  logic [1:0]    wb_bte_i,
  output logic [dw-1:0] wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic          wb_rty_o
);

  localparam int            IW    = $clog2(DEPTH);
  localparam logic [aw-1:0] LIMIT = aw'(DEPTH * 4);

  logic [dw-1:0] r_mem [DEPTH];

  logic [1:0]    r_state;
  logic          r_ack;
  logic          r_err;
  logic          r_first;
  logic [dw-1:0] r_dat;
  logic [aw-1:0] r_exp_adr;   // address of the beat whose data sits in r_dat

  logic [aw-1:0] w_nxt_adr;
  logic [IW-1:0] w_idx;
  logic [IW-1:0] w_nxt_idx;
  logic          w_oor;
  logic          w_nxt_oor;
  logic          w_match;
  logic          w_req;
  logic          w_wr;
  logic [dw-1:0] w_pref;

  wb_next_adr #(.aw(aw)) u_next_adr (
    .i_adr (r_exp_adr),
    .i_cti (wb_cti_i),
    .i_bte (wb_bte_i),
    .o_adr (w_nxt_adr)
  );

  assign w_idx     = wb_adr_i[2 +: IW];
  assign w_nxt_idx = w_nxt_adr[2 +: IW];
  assign w_oor     = (wb_adr_i >= LIMIT);
  assign w_nxt_oor = (w_nxt_adr >= LIMIT);

  // The first beat is always honoured; later beats must follow the sequence.
  assign w_match  = (wb_adr_i == r_exp_adr) | r_first;

  assign wb_ack_o = r_ack & ((r_state != ST_BURST) | w_match);
  assign wb_err_o = r_err | (r_ack & (r_state == ST_BURST) & ~w_match);
  assign wb_rty_o = 1'b0;
  assign wb_dat_o = r_dat;

  assign w_req = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
  assign w_wr  = wb_ack_o & (wb_we_i == WB_WRITE) & wb_cyc_i & wb_stb_i & ~w_oor;

  // Prefetch of the next beat; forward lanes being written this same edge
  // (constant-address bursts read back their own write).
  assign w_pref = (w_wr && (w_idx == w_nxt_idx))
                ? merge_lanes(r_mem[w_nxt_idx], wb_dat_i, wb_sel_i)
                : r_mem[w_nxt_idx];

  // NOTE: memory array has no reset; contents survive wb_rst_ni and map to RAM.
  always_ff @(posedge wb_clk_i) begin
    if (w_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (wb_sel_i[i]) r_mem[w_idx][8*i +: 8] <= wb_dat_i[8*i +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state   <= ST_IDLE;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_first   <= 1'b0;
      r_dat     <= '0;
      r_exp_adr <= '0;
    end else if (!wb_cyc_i) begin
      r_state <= ST_IDLE;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_first <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_exp_adr <= wb_adr_i;
            r_first   <= 1'b1;
            if (w_oor) begin
              r_err   <= 1'b1;
              r_dat   <= '0;
              r_state <= ST_CLASSIC;
            end else begin
              r_ack   <= 1'b1;
              r_dat   <= r_mem[w_idx];
              r_state <= is_burst(wb_cti_i) ? ST_BURST : ST_CLASSIC;
            end
          end
        end

        // Single-cycle ack/err pulse, then one idle cycle.
        ST_CLASSIC: begin
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
          r_first <= 1'b0;
          r_state <= ST_IDLE;
        end

        ST_BURST: begin
          if (!wb_stb_i || !w_match) begin
            // Master wait state or broken sequence: stop; a new stb restarts.
            r_ack   <= 1'b0;
            r_first <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_first <= 1'b0;
            if (wb_cti_i == CTI_EOB) begin
              r_ack   <= 1'b0;
              r_state <= ST_IDLE;
            end else if (w_nxt_oor) begin
              // Sequence runs off the end: the following beat gets err.
              r_ack   <= 1'b0;
              r_err   <= 1'b1;
              r_dat   <= '0;
              r_state <= ST_CLASSIC;
            end else begin
              r_dat     <= w_pref;
              r_exp_adr <= w_nxt_adr;
            end
          end
        end

        default: begin
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
          r_first <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_burst_ram.sv
// -----------------------------------------------------------------------------
// tb_wb_burst_ram
// Directed self-checking bench for wb_burst_ram: classic reads/writes,
// byte lanes, linear and wrap-4 bursts, out-of-range err, reset mid-burst.
// -----------------------------------------------------------------------------
module tb_wb_burst_ram;
  import wb_burst_ram_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_o;
  logic        ack;
  logic        err;
  logic        rty;

  int errors = 0;
  int checks = 0;

  // Burst results
  logic [31:0] b_dat [16];
  int          b_acks;
  int          b_errs;
  int          b_cycles;
  logic        b_tail_ack;
  logic        b_tail_err;

  wb_burst_ram dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wb_adr_i  (adr),
    .wb_dat_i  (wdat),
    .wb_sel_i  (sel),
    .wb_we_i   (we),
    .wb_cyc_i  (cyc),
    .wb_stb_i  (stb),
    .wb_cti_i  (cti),
    .wb_bte_i  (bte),
    .wb_dat_o  (dat_o),
    .wb_ack_o  (ack),
    .wb_err_o  (err),
    .wb_rty_o  (rty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Master-side address sequence, written as a mask/merge.
  function automatic logic [31:0] nxt(input logic [31:0] a, input logic [1:0] bt);
    logic [31:0] m;
    if (bt == 2'b00) return a + 32'd4;
    m = (32'd8 << bt) - 32'd1;   // 0xF, 0x1F, 0x3F
    return (a & ~m) | ((a + 32'd4) & m);
  endfunction

  // Classic single access; cycles counts clocks from drive until ack/err seen.
  task automatic classic(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic got_ack, output logic got_err,
                         output logic [31:0] rd, output int cycles);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = wr; adr = a; wdat = d; sel = s;
    cti = CTI_CLASSIC; bte = BTE_LINEAR;
    got_ack = 1'b0; got_err = 1'b0; rd = '0; cycles = 0;
    while (!(got_ack || got_err) && cycles < 10) begin
      @(negedge clk);
      cycles++;
      got_ack = ack; got_err = err; rd = dat_o;
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  // Burst of n beats; write data is wbase + beat number.
  task automatic burst(input logic wr, input logic [31:0] a0, input logic [1:0] bt,
                       input int n, input logic [31:0] wbase);
    logic [31:0] a;
    b_acks = 0; b_errs = 0; b_cycles = 0; b_tail_ack = 1'b0; b_tail_err = 1'b0;
    a = a0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = wr; adr = a; sel = 4'hF; bte = bt; wdat = wbase;
    cti = (n == 1) ? CTI_EOB : CTI_INCR;
    while (b_acks < n && b_errs == 0 && b_cycles < 40) begin
      @(negedge clk);
      b_cycles++;
      if (ack) begin
        b_dat[b_acks] = dat_o;
        b_acks++;
        @(posedge clk); #1;
        if (b_acks < n) begin
          a = nxt(a, bt); adr = a; wdat = wbase + b_acks;
          if (b_acks == n - 1) cti = CTI_EOB;
        end else begin
          stb = 1'b0;   // hold cyc one more cycle to observe the tail
        end
      end else if (err) begin
        b_errs++;
      end
    end
    if (b_acks == n) begin
      @(negedge clk);
      b_tail_ack = ack; b_tail_err = err;
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  logic        g_ack;
  logic        g_err;
  logic [31:0] g_dat;
  int          g_cyc;
  int          beats;
  int          cnt;

  initial begin
    rst_n = 1'b0; adr = '0; wdat = '0; sel = '0; we = 1'b0;
    cyc = 1'b0; stb = 1'b0; cti = '0; bte = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_dat", dat_o, 32'h0);
    check("rst_rty", 32'(rty), 32'd0);
    rst_n = 1'b1;

    // Classic write then read
    classic(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, g_ack, g_err, g_dat, g_cyc);
    check("cw_ack", 32'(g_ack), 32'd1);
    check("cw_cycles", 32'(g_cyc), 32'd2);
    classic(1'b0, 32'h10, 32'h0, 4'hF, g_ack, g_err, g_dat, g_cyc);
    check("cr_ack", 32'(g_ack), 32'd1);
    check("cr_cycles", 32'(g_cyc), 32'd2);
    check("cr_dat", g_dat, 32'hDEADBEEF);

    // Byte-lane write
    classic(1'b1, 32'h10, 32'h0000AB00, 4'b0010, g_ack, g_err, g_dat, g_cyc);
    classic(1'b0, 32'h10, 32'h0, 4'hF, g_ack, g_err, g_dat, g_cyc);
    check("lane_dat", g_dat, 32'hDEADABEF);

    // Linear burst write 0..7 from 0x40, then burst read
    burst(1'b1, 32'h40, BTE_LINEAR, 8, 32'd0);
    check("bw_acks", 32'(b_acks), 32'd8);
    check("bw_cycles", 32'(b_cycles), 32'd9);
    check("bw_tail_ack", 32'(b_tail_ack), 32'd0);
    burst(1'b0, 32'h40, BTE_LINEAR, 8, 32'd0);
    check("br_acks", 32'(b_acks), 32'd8);
    check("br_cycles", 32'(b_cycles), 32'd9);
    check("br_tail_ack", 32'(b_tail_ack), 32'd0);
    check("br_tail_err", 32'(b_tail_err), 32'd0);
    for (int k = 0; k < 8; k++) check($sformatf("br_dat%0d", k), b_dat[k], 32'(k));

    // Wrap-4 read from 0x48: 0x48, 0x4C, 0x40, 0x44
    burst(1'b0, 32'h48, BTE_WRAP4, 4, 32'd0);
    check("w4_acks", 32'(b_acks), 32'd4);
    check("w4_dat0", b_dat[0], 32'd2);
    check("w4_dat1", b_dat[1], 32'd3);
    check("w4_dat2", b_dat[2], 32'd0);
    check("w4_dat3", b_dat[3], 32'd1);

    // Out of range: err, no ack, zero data, word 0 (alias) untouched
    classic(1'b1, 32'h0, 32'h11223344, 4'hF, g_ack, g_err, g_dat, g_cyc);
    classic(1'b1, 32'h400, 32'hCAFEF00D, 4'hF, g_ack, g_err, g_dat, g_cyc);
    check("oor_err", 32'(g_err), 32'd1);
    check("oor_ack", 32'(g_ack), 32'd0);
    check("oor_dat", g_dat, 32'h0);
    check("oor_cycles", 32'(g_cyc), 32'd2);
    classic(1'b0, 32'h0, 32'h0, 4'hF, g_ack, g_err, g_dat, g_cyc);
    check("oor_mem", g_dat, 32'h11223344);

    // Burst running off the end: beat 1 ack, beat 2 err
    burst(1'b0, 32'h3FC, BTE_LINEAR, 4, 32'd0);
    check("end_acks", 32'(b_acks), 32'd1);
    check("end_errs", 32'(b_errs), 32'd1);

    // Reset asserted during beat 3 of a read burst
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h40; cti = CTI_INCR; bte = BTE_LINEAR;
    beats = 0; cnt = 0;
    while (beats < 3 && cnt < 20) begin
      @(negedge clk);
      cnt++;
      if (ack) begin
        beats++;
        if (beats < 3) begin
          @(posedge clk); #1;
          adr = adr + 32'd4;
        end
      end
    end
    check("mid_beats", 32'(beats), 32'd3);
    check("mid_dat", dat_o, 32'd2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ack", 32'(ack), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_dat", dat_o, 32'h0);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    classic(1'b0, 32'h10, 32'h0, 4'hF, g_ack, g_err, g_dat, g_cyc);
    check("post_ack", 32'(g_ack), 32'd1);
    check("post_cycles", 32'(g_cyc), 32'd2);
    check("post_dat", g_dat, 32'hDEADABEF);
    classic(1'b0, 32'h54, 32'h0, 4'hF, g_ack, g_err, g_dat, g_cyc);
    check("post_dat2", g_dat, 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
